// File: rtl/freq_gen_tx.sv
// Programmable square-wave source: fixed-count or continuous periods with start/stop/done handshake.
// Define FREQ_GEN_DUTY_EN to add a separately programmable high-phase length (high_len).
module freq_gen_tx #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] half_period,
`ifdef FREQ_GEN_DUTY_EN
   input  logic [DIV_W-1:0] high_len,
`endif
   input  logic [CNT_W-1:0] n_cycles,
   input  logic             start,
   input  logic             stop,
   output logic             out_freq,
   output logic             busy,
   output logic             cycle_tick,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t           state, stateNext;
   logic [DIV_W-1:0] halfReg, halfNext;
   logic [DIV_W-1:0] highReg, highNext;
   logic [DIV_W-1:0] phaseCnt, phaseNext;
   logic [CNT_W-1:0] nReg, nNext;
   logic [CNT_W-1:0] periodCnt, periodNext;
   logic             outNext, busyNext, tickNext, doneNext;
   logic [DIV_W-1:0] loadHalf, loadHigh, startHigh;

   // Zero-length phases are meaningless, so they are stretched to one clock.
   function automatic logic [DIV_W-1:0] clampLen(input logic [DIV_W-1:0] v);
      return (v == '0) ? DIV_W'(1) : v;
   endfunction

   // A load in the same cycle as start must take effect immediately, so the start path bypasses the register.
   always_comb begin
      loadHalf = clampLen(half_period);
`ifdef FREQ_GEN_DUTY_EN
      loadHigh = clampLen(high_len);
`else
      loadHigh = loadHalf;
`endif
      startHigh = load ? loadHigh : highReg;
   end

   always_comb begin
      stateNext  = state;
      halfNext   = halfReg;
      highNext   = highReg;
      phaseNext  = phaseCnt;
      nNext      = nReg;
      periodNext = periodCnt;
      outNext    = out_freq;
      busyNext   = busy;
      tickNext   = 1'b0;
      doneNext   = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               halfNext = loadHalf;
               highNext = loadHigh;
            end
            if (start && !stop) begin
               stateNext  = HIGH;
               phaseNext  = startHigh - DIV_W'(1);
               nNext      = n_cycles;
               periodNext = '0;
               outNext    = 1'b1;
               busyNext   = 1'b1;
            end
         end
         HIGH: begin
            if (stop) begin
               stateNext = IDLE;
               outNext   = 1'b0;
               busyNext  = 1'b0;
            end else if (phaseCnt == '0) begin
               stateNext = LOW;
               phaseNext = halfReg - DIV_W'(1);
               outNext   = 1'b0;
            end else begin
               phaseNext = phaseCnt - DIV_W'(1);
            end
         end
         LOW: begin
            // Stop wins over period completion, so the final tick and done are suppressed.
            if (stop) begin
               stateNext = IDLE;
               outNext   = 1'b0;
               busyNext  = 1'b0;
            end else if (phaseCnt == '0) begin
               tickNext   = 1'b1;
               periodNext = periodCnt + CNT_W'(1);
               if (nReg != '0 && periodNext == nReg) begin
                  stateNext = IDLE;
                  outNext   = 1'b0;
                  busyNext  = 1'b0;
                  doneNext  = 1'b1;
               end else begin
                  stateNext = HIGH;
                  phaseNext = highReg - DIV_W'(1);
                  outNext   = 1'b1;
               end
            end else begin
               phaseNext = phaseCnt - DIV_W'(1);
            end
         end
         default: begin
            stateNext = IDLE;
            outNext   = 1'b0;
            busyNext  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         halfReg    <= DIV_W'(1);
         highReg    <= DIV_W'(1);
         phaseCnt   <= '0;
         nReg       <= '0;
         periodCnt  <= '0;
         out_freq   <= 1'b0;
         busy       <= 1'b0;
         cycle_tick <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= stateNext;
         halfReg    <= halfNext;
         highReg    <= highNext;
         phaseCnt   <= phaseNext;
         nReg       <= nNext;
         periodCnt  <= periodNext;
         out_freq   <= outNext;
         busy       <= busyNext;
         cycle_tick <= tickNext;
         done       <= doneNext;
      end
   end

endmodule

// File: tb/tb_freq_gen_tx.sv
// Directed self-checking bench for freq_gen_tx; outputs are compared as {out_freq,busy,cycle_tick,done}.
// Define FREQ_GEN_DUTY_EN to also exercise the high_len feature.
module tb_freq_gen_tx;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] half_period;
`ifdef FREQ_GEN_DUTY_EN
   logic [15:0] high_len;
`endif
   logic [7:0]  n_cycles;
   logic        start;
   logic        stop;
   logic        out_freq, busy, cycle_tick, done;

   int compared   = 0;
   int mismatched = 0;

   freq_gen_tx #(.DIV_W(16), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .half_period(half_period),
`ifdef FREQ_GEN_DUTY_EN
      .high_len   (high_len),
`endif
      .n_cycles   (n_cycles),
      .start      (start),
      .stop       (stop),
      .out_freq   (out_freq),
      .busy       (busy),
      .cycle_tick (cycle_tick),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled on the falling edge, away from the active edge.
   task automatic stepCycle();
      @(negedge clk);
   endtask

   // Expected outputs k cycles after the start cycle for a run of n periods (n==0: continuous).
   function automatic logic [3:0] expVec(int k, int hi, int lo, int n);
      int per;
      int pos;
      per = hi + lo;
      if (k < 1) return 4'b0000;
      if (n != 0 && k == per * n + 1) return 4'b0011;
      if (n != 0 && k > per * n + 1) return 4'b0000;
      pos = (k - 1) % per;
      return {(pos < hi), 1'b1, (k > 1 && pos == 0), 1'b0};
   endfunction

   function automatic logic [3:0] obsVec();
      return {out_freq, busy, cycle_tick, done};
   endfunction

   task automatic test_reset();
      rst = 1'b0; start = 1'b1; n_cycles = 8'd1; load = 1'b0; stop = 1'b0; half_period = 16'd0;
      for (int i = 0; i < 2; i++) begin
         stepCycle();
         compared++;
         if (obsVec() !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset cyc=%0d got=%b want=0000", i, obsVec());
         end
      end
      rst = 1'b1; start = 1'b0;
      stepCycle();
      compared++;
      if (obsVec() !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL reset_release got=%b want=0000", obsVec());
      end
   endtask

   task automatic test_single();
      load = 1'b1; half_period = 16'd2;
      stepCycle();
      load = 1'b0; start = 1'b1; n_cycles = 8'd1;
      stepCycle();
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         compared++;
         if (obsVec() !== expVec(k, 2, 2, 1)) begin
            mismatched++;
            $display("[TB] FAIL single k=%0d got=%b want=%b", k, obsVec(), expVec(k, 2, 2, 1));
         end
         stepCycle();
      end
   endtask

   task automatic test_multi();
      int ticks;
      ticks = 0;
      load = 1'b1; half_period = 16'd5;
      stepCycle();
      load = 1'b0; start = 1'b1; n_cycles = 8'd3;
      stepCycle();
      start = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         if (cycle_tick) ticks++;
         compared++;
         if (obsVec() !== expVec(k, 5, 5, 3)) begin
            mismatched++;
            $display("[TB] FAIL multi k=%0d got=%b want=%b", k, obsVec(), expVec(k, 5, 5, 3));
         end
         stepCycle();
      end
      compared++;
      if (ticks != 3) begin
         mismatched++;
         $display("[TB] FAIL multi_ticks got=%0d want=3", ticks);
      end
   endtask

   task automatic test_continuous();
      load = 1'b1; half_period = 16'd3;
      stepCycle();
      load = 1'b0; start = 1'b1; n_cycles = 8'd0;
      stepCycle();
      start = 1'b0;
      for (int k = 1; k <= 101; k++) begin
         compared++;
         if (obsVec() !== expVec(k, 3, 3, 0)) begin
            mismatched++;
            $display("[TB] FAIL continuous k=%0d got=%b want=%b", k, obsVec(), expVec(k, 3, 3, 0));
         end
         if (k == 101) stop = 1'b1;
         stepCycle();
      end
      stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         compared++;
         if (obsVec() !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL after_stop cyc=%0d got=%b want=0000", i, obsVec());
         end
         stepCycle();
      end
   endtask

   task automatic test_load_ignore();
      load = 1'b1; half_period = 16'd4;
      stepCycle();
      load = 1'b0; start = 1'b1; n_cycles = 8'd2;
      stepCycle();
      start = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         compared++;
         if (obsVec() !== expVec(k, 4, 4, 2)) begin
            mismatched++;
            $display("[TB] FAIL busy_load k=%0d got=%b want=%b", k, obsVec(), expVec(k, 4, 4, 2));
         end
         if (k == 3) begin
            load = 1'b1; half_period = 16'd9; start = 1'b1; n_cycles = 8'd5;
         end else begin
            load = 1'b0; start = 1'b0;
         end
         stepCycle();
      end
      load = 1'b1; half_period = 16'd0; start = 1'b1; n_cycles = 8'd1;
      stepCycle();
      load = 1'b0; start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         compared++;
         if (obsVec() !== expVec(k, 1, 1, 1)) begin
            mismatched++;
            $display("[TB] FAIL load_start_hp0 k=%0d got=%b want=%b", k, obsVec(), expVec(k, 1, 1, 1));
         end
         stepCycle();
      end
   endtask

   task automatic test_back_to_back();
      load = 1'b1; half_period = 16'd2;
      stepCycle();
      load = 1'b0; start = 1'b1; n_cycles = 8'd1;
      stepCycle();
      start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         compared++;
         if (obsVec() !== expVec(k, 2, 2, 1)) begin
            mismatched++;
            $display("[TB] FAIL b2b_first k=%0d got=%b want=%b", k, obsVec(), expVec(k, 2, 2, 1));
         end
         if (k == 5) begin
            start = 1'b1; n_cycles = 8'd2;
         end
         stepCycle();
      end
      start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         compared++;
         if (obsVec() !== expVec(k, 2, 2, 2)) begin
            mismatched++;
            $display("[TB] FAIL b2b_second k=%0d got=%b want=%b", k, obsVec(), expVec(k, 2, 2, 2));
         end
         stepCycle();
      end
   endtask

   task automatic test_stop_priority();
      start = 1'b1; stop = 1'b1; n_cycles = 8'd1;
      stepCycle();
      start = 1'b0; stop = 1'b0;
      compared++;
      if (obsVec() !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL stop_over_start got=%b want=0000", obsVec());
      end
      load = 1'b1; half_period = 16'd1; start = 1'b1; n_cycles = 8'd1;
      stepCycle();
      load = 1'b0; start = 1'b0;
      compared++;
      if (obsVec() !== 4'b1100) begin
         mismatched++;
         $display("[TB] FAIL stop_run_high got=%b want=1100", obsVec());
      end
      stepCycle();
      compared++;
      if (obsVec() !== 4'b0100) begin
         mismatched++;
         $display("[TB] FAIL stop_run_low got=%b want=0100", obsVec());
      end
      stop = 1'b1;
      stepCycle();
      stop = 1'b0;
      compared++;
      if (obsVec() !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL stop_over_done got=%b want=0000", obsVec());
      end
   endtask

   task automatic test_reset_mid();
      load = 1'b1; half_period = 16'd3;
      stepCycle();
      load = 1'b0; start = 1'b1; n_cycles = 8'd0;
      stepCycle();
      start = 1'b0;
      stepCycle();
      stepCycle();
      rst = 1'b0;
      stepCycle();
      rst = 1'b1;
      compared++;
      if (obsVec() !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL reset_mid got=%b want=0000", obsVec());
      end
      start = 1'b1; n_cycles = 8'd1;
      stepCycle();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         compared++;
         if (obsVec() !== expVec(k, 1, 1, 1)) begin
            mismatched++;
            $display("[TB] FAIL reset_period k=%0d got=%b want=%b", k, obsVec(), expVec(k, 1, 1, 1));
         end
         stepCycle();
      end
   endtask

`ifdef FREQ_GEN_DUTY_EN
   task automatic test_duty();
      load = 1'b1; half_period = 16'd3; high_len = 16'd1;
      stepCycle();
      load = 1'b0; start = 1'b1; n_cycles = 8'd2;
      stepCycle();
      start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         compared++;
         if (obsVec() !== expVec(k, 1, 3, 2)) begin
            mismatched++;
            $display("[TB] FAIL duty k=%0d got=%b want=%b", k, obsVec(), expVec(k, 1, 3, 2));
         end
         stepCycle();
      end
      high_len = 16'd0;
   endtask
`endif

   initial begin
      rst = 1'b0; load = 1'b0; half_period = 16'd0; n_cycles = 8'd0; start = 1'b0; stop = 1'b0;
`ifdef FREQ_GEN_DUTY_EN
      high_len = 16'd0;
`endif
      test_reset();
      test_single();
      test_multi();
      test_continuous();
      test_load_ignore();
      test_back_to_back();
      test_stop_priority();
      test_reset_mid();
`ifdef FREQ_GEN_DUTY_EN
      test_duty();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
